// File: rtl/ray_aabb_packer_pkg.sv
// ray_aabb_pkg: shared operand width, word indices and assembled test-vector type
package ray_aabb_pkg;
  localparam int W = 24;
  localparam int NWORDS = 12;
  localparam logic [3:0] IDX_X0 = 4'd0;
  localparam logic [3:0] IDX_Y0 = 4'd1;
  localparam logic [3:0] IDX_Z0 = 4'd2;
  localparam logic [3:0] IDX_X1 = 4'd3;
  localparam logic [3:0] IDX_Y1 = 4'd4;
  localparam logic [3:0] IDX_Z1 = 4'd5;
  localparam logic [3:0] IDX_X2 = 4'd6;
  localparam logic [3:0] IDX_Y2 = 4'd7;
  localparam logic [3:0] IDX_Z2 = 4'd8;
  localparam logic [3:0] IDX_DIVX = 4'd9;
  localparam logic [3:0] IDX_DIVY = 4'd10;
  localparam logic [3:0] IDX_DIVZ = 4'd11;
  typedef struct packed {
    logic [W-1:0] x0, y0, z0, x1, y1, z1, x2, y2, z2, divx, divy, divz;
    logic x, y, z;
  } ray_aabb_vec_t;
endpackage

// File: rtl/ray_aabb_packer_if.sv
// ray_aabb_packer_if: word-serial input stream and parallel test-vector output bundle
//   master: drives in_valid/in_data/in_sof/in_dir and out_ready (stream source + vector sink)
//   slave:  the packer, drives in_ready, operands, direction bits, out_valid, out_tag, sync_err_cnt
interface ray_aabb_packer_if #(parameter int TAGW = 16);
  import ray_aabb_pkg::*;
  logic in_valid, in_ready, in_sof;
  logic [W-1:0] in_data;
  logic [2:0] in_dir;
  logic [W-1:0] x0, y0, z0, x1, y1, z1, x2, y2, z2, divx, divy, divz;
  logic x, y, z;
  logic out_valid, out_ready;
  logic [TAGW-1:0] out_tag;
  logic [7:0] sync_err_cnt;
  modport master (
    output in_valid, in_data, in_sof, in_dir, out_ready,
    input  in_ready, x0, y0, z0, x1, y1, z1, x2, y2, z2, divx, divy, divz,
    input  x, y, z, out_valid, out_tag, sync_err_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sof, in_dir, out_ready,
    output in_ready, x0, y0, z0, x1, y1, z1, x2, y2, z2, divx, divy, divz,
    output x, y, z, out_valid, out_tag, sync_err_cnt
  );
endinterface

// File: rtl/ray_aabb_packer_out_reg.sv
// ray_aabb_out_reg: output vector register with valid/ready handshake and tag
//   load_i/vec_i/tag_i: new vector from the packer; out_ready_i: downstream accept
//   out_valid_o/vec_o/tag_o: presented vector, held stable while stalled
module ray_aabb_out_reg
  import ray_aabb_pkg::*;
#(
  parameter int TAGW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            out_ready_i,
  input  ray_aabb_vec_t   vec_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            out_valid_o,
  output ray_aabb_vec_t   vec_o,
  output logic [TAGW-1:0] tag_o
);
  logic valid_q, valid_d;
  ray_aabb_vec_t vec_q, vec_d;
  logic [TAGW-1:0] tag_q, tag_d;
  always_comb begin
    valid_d = load_i | (valid_q & ~out_ready_i);
    vec_d = load_i ? vec_i : vec_q;
    tag_d = load_i ? tag_i : tag_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      vec_q <= '0;
      tag_q <= '0;
    end else begin
      valid_q <= valid_d;
      vec_q <= vec_d;
      tag_q <= tag_d;
    end
  end
  assign out_valid_o = valid_q;
  assign vec_o = vec_q;
  assign tag_o = tag_q;
endmodule

// File: rtl/ray_aabb_packer.sv
// ray_aabb_packer: assembles 12-word operand groups into Ray_AABB test vectors
//   clk, rst (async, active-low); bus: ray_aabb_packer_if.slave carrying the
//   input stream, assembled vector with valid/ready/tag and the resync error count
module ray_aabb_packer
  import ray_aabb_pkg::*;
#(
  parameter int TAGW = 16
) (
  input logic clk,
  input logic rst,
  ray_aabb_packer_if.slave bus
);
  logic [3:0] idx_q, idx_d;
  logic [NWORDS-2:0][W-1:0] asm_q, asm_d;
  logic [TAGW-1:0] grp_q, grp_d;
  logic [7:0] err_q, err_d;
  logic last, acc, resync, load;
  ray_aabb_vec_t vec, vq;
  assign last = idx_q == IDX_DIVZ;
  // only the final word can stall: it needs the output register free
  assign bus.in_ready = rst & ~(last & bus.out_valid & ~bus.out_ready);
  assign acc = bus.in_valid & bus.in_ready;
  // sof mid-group restarts the group with this beat as word 0
  assign resync = acc & bus.in_sof & (idx_q != IDX_X0);
  assign load = acc & last & ~resync;
  always_comb begin
    idx_d = ~acc ? idx_q : resync ? 4'd1 : last ? IDX_X0 : idx_q + 4'd1;
    asm_d = asm_q;
    if (acc & ~load) asm_d[resync ? IDX_X0 : idx_q] = bus.in_data;
    grp_d = grp_q + TAGW'(load);
    err_d = err_q + {7'd0, resync & (err_q != 8'hff)};
    vec.x0 = asm_q[IDX_X0];
    vec.y0 = asm_q[IDX_Y0];
    vec.z0 = asm_q[IDX_Z0];
    vec.x1 = asm_q[IDX_X1];
    vec.y1 = asm_q[IDX_Y1];
    vec.z1 = asm_q[IDX_Z1];
    vec.x2 = asm_q[IDX_X2];
    vec.y2 = asm_q[IDX_Y2];
    vec.z2 = asm_q[IDX_Z2];
    vec.divx = asm_q[IDX_DIVX];
    vec.divy = asm_q[IDX_DIVY];
    vec.divz = bus.in_data;
    vec.x = bus.in_dir[2];
    vec.y = bus.in_dir[1];
    vec.z = bus.in_dir[0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= IDX_X0;
      asm_q <= '0;
      grp_q <= '0;
      err_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      grp_q <= grp_d;
      err_q <= err_d;
    end
  end
  ray_aabb_out_reg #(.TAGW(TAGW)) u_out (
    .clk(clk),
    .rst(rst),
    .load_i(load),
    .out_ready_i(bus.out_ready),
    .vec_i(vec),
    .tag_i(grp_q),
    .out_valid_o(bus.out_valid),
    .vec_o(vq),
    .tag_o(bus.out_tag)
  );
  assign bus.x0 = vq.x0;
  assign bus.y0 = vq.y0;
  assign bus.z0 = vq.z0;
  assign bus.x1 = vq.x1;
  assign bus.y1 = vq.y1;
  assign bus.z1 = vq.z1;
  assign bus.x2 = vq.x2;
  assign bus.y2 = vq.y2;
  assign bus.z2 = vq.z2;
  assign bus.divx = vq.divx;
  assign bus.divy = vq.divy;
  assign bus.divz = vq.divz;
  assign bus.x = vq.x;
  assign bus.y = vq.y;
  assign bus.z = vq.z;
  assign bus.sync_err_cnt = err_q;
endmodule

// File: tb/tb_ray_aabb_packer.sv
// tb_ray_aabb_packer: directed bench for the ray_aabb_packer word-to-vector assembler
module tb_ray_aabb_packer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  always #5 clk = ~clk;
  ray_aabb_packer_if #(.TAGW(16)) bus ();
  ray_aabb_packer_if #(.TAGW(3)) bus2 ();
  ray_aabb_packer #(.TAGW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  ray_aabb_packer #(.TAGW(3)) dut_w (.clk(clk), .rst(rst), .bus(bus2));

  task automatic beat(input logic [23:0] d, input logic sof, input logic [2:0] dir);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_sof = sof;
    bus.in_dir = dir;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout data=%0d in_ready stuck at 0, need 1", d);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b need 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b need 0", bus.in_ready); end
    checks++; if (bus.out_tag !== 16'd0) begin errors++; $display("FAIL rst_tag got %0d need 0", bus.out_tag); end
    checks++; if (bus.sync_err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err got %0d need 0", bus.sync_err_cnt); end
    checks++; if (bus.x0 !== 24'd0 || bus.divz !== 24'd0 || {bus.x, bus.y, bus.z} !== 3'b000) begin
      errors++; $display("FAIL rst_data x0=%0d divz=%0d dir=%b need 0", bus.x0, bus.divz, {bus.x, bus.y, bus.z});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b need 1", bus.in_ready); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      beat(24'(i), 1'b0, 3'b101);
      if (i == 11) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b need 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b need 1", bus.out_valid); end
    checks++; if (bus.x0 !== 24'd1 || bus.y0 !== 24'd2 || bus.z0 !== 24'd3 || bus.x1 !== 24'd4 || bus.y1 !== 24'd5 || bus.z1 !== 24'd6) begin
      errors++; $display("FAIL single_pt01 got %0d %0d %0d %0d %0d %0d need 1..6", bus.x0, bus.y0, bus.z0, bus.x1, bus.y1, bus.z1);
    end
    checks++; if (bus.x2 !== 24'd7 || bus.y2 !== 24'd8 || bus.z2 !== 24'd9 || bus.divx !== 24'd10 || bus.divy !== 24'd11 || bus.divz !== 24'd12) begin
      errors++; $display("FAIL single_pt2div got %0d %0d %0d %0d %0d %0d need 7..12", bus.x2, bus.y2, bus.z2, bus.divx, bus.divy, bus.divz);
    end
    checks++; if ({bus.x, bus.y, bus.z} !== 3'b101) begin errors++; $display("FAIL single_dir got %b need 101", {bus.x, bus.y, bus.z}); end
    checks++; if (bus.out_tag !== 16'd0) begin errors++; $display("FAIL single_tag got %0d need 0", bus.out_tag); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_clear got %b need 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    stalls = 0;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 12; i++) begin
        beat(24'(g * 100 + i), 1'b0, 3'b011);
        if (i == 11) begin
          checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 16'(g)) begin
            errors++; $display("FAIL b2b_vec%0d valid=%b tag=%0d need 1/%0d", g, bus.out_valid, bus.out_tag, g);
          end
          checks++; if (bus.x0 !== 24'(g * 100) || bus.divz !== 24'(g * 100 + 11)) begin
            errors++; $display("FAIL b2b_data%0d x0=%0d divz=%0d need %0d/%0d", g, bus.x0, bus.divz, g * 100, g * 100 + 11);
          end
        end else if (i == 5) begin
          checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d got %b need 0", g, bus.out_valid); end
        end
      end
    end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls got %0d need 0", stalls); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) beat(24'(i), 1'b0, 3'b110);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 16'd0) begin
      errors++; $display("FAIL bp_g0 valid=%b tag=%0d need 1/0", bus.out_valid, bus.out_tag);
    end
    for (int i = 21; i <= 31; i++) beat(24'(i), 1'b0, 3'b001);
    bus.in_valid = 1'b1;
    bus.in_data = 24'd32;
    bus.in_dir = 3'b001;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got %b need 0", bus.in_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold valid=%b in_ready=%b need 1/0", bus.out_valid, bus.in_ready);
    end
    checks++; if (bus.x0 !== 24'd1 || bus.divy !== 24'd11 || bus.divz !== 24'd12 || {bus.x, bus.y, bus.z} !== 3'b110 || bus.out_tag !== 16'd0) begin
      errors++; $display("FAIL bp_stable x0=%0d divy=%0d divz=%0d dir=%b tag=%0d need 1/11/12/110/0", bus.x0, bus.divy, bus.divz, {bus.x, bus.y, bus.z}, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b need 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 16'd1) begin
      errors++; $display("FAIL bp_g1 valid=%b tag=%0d need 1/1", bus.out_valid, bus.out_tag);
    end
    checks++; if (bus.x0 !== 24'd21 || bus.divy !== 24'd31 || bus.divz !== 24'd32 || {bus.x, bus.y, bus.z} !== 3'b001) begin
      errors++; $display("FAIL bp_g1_data x0=%0d divy=%0d divz=%0d dir=%b need 21/31/32/001", bus.x0, bus.divy, bus.divz, {bus.x, bus.y, bus.z});
    end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_clear got %b need 0", bus.out_valid); end
  endtask

  task automatic test_resync();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 41; i <= 44; i++) beat(24'(i), 1'b0, 3'b000);
    beat(24'd50, 1'b1, 3'b000);
    checks++; if (bus.sync_err_cnt !== 8'd1) begin errors++; $display("FAIL resync_cnt got %0d need 1", bus.sync_err_cnt); end
    for (int i = 51; i <= 61; i++) begin
      beat(24'(i), 1'b0, 3'b111);
      if (i == 57) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL resync_stale got %b need 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 16'd0) begin
      errors++; $display("FAIL resync_vec valid=%b tag=%0d need 1/0", bus.out_valid, bus.out_tag);
    end
    checks++; if (bus.x0 !== 24'd50 || bus.y0 !== 24'd51 || bus.divz !== 24'd61) begin
      errors++; $display("FAIL resync_data x0=%0d y0=%0d divz=%0d need 50/51/61", bus.x0, bus.y0, bus.divz);
    end
    beat(24'd70, 1'b1, 3'b000);
    checks++; if (bus.sync_err_cnt !== 8'd1) begin errors++; $display("FAIL sof_idx0 got %0d need 1", bus.sync_err_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) beat(24'(i), 1'b1, 3'b000);
    checks++; if (bus.sync_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d need 255", bus.sync_err_cnt); end
    for (int i = 0; i < 45; i++) beat(24'(i), 1'b1, 3'b000);
    checks++; if (bus.sync_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d need 255", bus.sync_err_cnt); end
  endtask

  task automatic test_reset_midfill();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) beat(24'(i), 1'b0, 3'b111);
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst valid=%b in_ready=%b need 0/0", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 200; i <= 211; i++) begin
      beat(24'(i), 1'b0, 3'b010);
      if (i == 204) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early got %b need 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 16'd0) begin
      errors++; $display("FAIL midrst_vec valid=%b tag=%0d need 1/0", bus.out_valid, bus.out_tag);
    end
    checks++; if (bus.x0 !== 24'd200 || bus.divz !== 24'd211 || {bus.x, bus.y, bus.z} !== 3'b010) begin
      errors++; $display("FAIL midrst_data x0=%0d divz=%0d dir=%b need 200/211/010", bus.x0, bus.divz, {bus.x, bus.y, bus.z});
    end
  endtask

  task automatic test_tag_wrap();
    do_reset();
    bus2.out_ready = 1'b1;
    for (int g = 0; g < 9; g++) begin
      for (int i = 0; i < 12; i++) begin
        bus2.in_valid = 1'b1;
        bus2.in_data = 24'(g * 12 + i + 1);
        @(posedge clk);
        #1;
      end
      checks++; if (bus2.out_valid !== 1'b1 || bus2.out_tag !== 3'(g % 8)) begin
        errors++; $display("FAIL wrap_tag%0d valid=%b tag=%0d need 1/%0d", g, bus2.out_valid, bus2.out_tag, g % 8);
      end
    end
    bus2.in_valid = 1'b0;
    checks++; if (bus2.divz !== 24'd108 || bus2.x0 !== 24'd97) begin
      errors++; $display("FAIL wrap_data x0=%0d divz=%0d need 97/108", bus2.x0, bus2.divz);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_sof = 1'b0;
    bus.in_dir = '0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_data = '0;
    bus2.in_sof = 1'b0;
    bus2.in_dir = '0;
    bus2.out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_resync();
    test_saturation();
    test_reset_midfill();
    test_tag_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
